// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcode, frame, error and receiver-state types plus the reference CRC4
package alu_pkg;

    typedef enum logic [2:0] {
        AND     = 3'b000,
        OR      = 3'b001,
        ADD     = 3'b100,
        SUB     = 3'b101,
        UNKNOWN = 3'b010
    } alu_op_t;

    localparam logic DATA = 1'b0;
    localparam logic CMD  = 1'b1;

    typedef struct packed {
        logic data;
        logic crc;
        logic op;
    } err_flags_t;

    typedef enum logic [2:0] {IDLE, START, BITS, STOP, DONE, ERR, REPORT} rx_state_t;

    function automatic logic op_legal(input logic [2:0] op);
        return op inside {AND, OR, ADD, SUB};
    endfunction

    // Serial x^4+x+1 over {B, A, 1'b1, op}, MSB first, seed 0
    function automatic logic [3:0] get_CRC4_d68(input logic [67:0] d);
        logic [3:0] c;
        logic fb;
        c = 4'h0;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ d[i];
            c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
        end
        return c;
    endfunction

endpackage

// File: rtl/alu_crc4_ser.sv
// alu_crc4_ser: bit-serial CRC4 LFSR for x^4+x+1
module alu_crc4_ser (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [3:0] crc
);

    logic fb;

    assign fb = crc[3] ^ din;

    always_ff @(posedge clk) begin
        if (rst || clr)
            crc <= 4'h0;
        else if (en)
            crc <= {crc[2], crc[1], crc[0] ^ fb, fb};
    end

endmodule

// File: rtl/alu_serial_rx.sv
// alu_serial_rx: deserializes ALU packets from sin, checks length/CRC/opcode, reports one result per packet
import alu_pkg::*;

module alu_serial_rx #(
    parameter int DATA_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sin,
    output logic        out_valid,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [2:0]  out_op,
    output logic [2:0]  out_err,
    output logic        busy
);

    rx_state_t  state, state_nxt;
    logic       ftype;
    logic [2:0] bit_cnt;
    logic [3:0] cnt;
    logic [63:0] shreg;
    logic [6:0] cmd;
    logic       rep, rep_bad;
    logic [3:0] crc;
    logic       crc_en, crc_din;
    err_flags_t err;

    // Cmd frame feeds a forced 1 in place of its leading 0, then op; CRC nibble is excluded
    assign crc_en  = state == BITS && (ftype == DATA || bit_cnt >= 3'd4);
    assign crc_din = (ftype == CMD && bit_cnt == 3'd7) ? 1'b1 : sin;
    assign busy    = state != REPORT && (state != IDLE || cnt != 4'd0);

    alu_crc4_ser u_crc (
        .clk (clk),
        .rst (rst),
        .clr (rep),
        .en  (crc_en),
        .din (crc_din),
        .crc (crc)
    );

    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nxt;
    end

    // DONE, ERR and REPORT all accept a start bit so frames may run back to back
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = sin ? IDLE : START;
            START:   state_nxt = BITS;
            BITS:    state_nxt = bit_cnt == 3'd0 ? STOP : BITS;
            STOP:    state_nxt = sin ? DONE : ERR;
            DONE:    state_nxt = !sin ? START : (ftype == CMD ? REPORT : IDLE);
            ERR:     state_nxt = !sin ? START : REPORT;
            REPORT:  state_nxt = sin ? IDLE : START;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        err      = '0;
        err.data = rep_bad || cnt != 4'(DATA_FRAMES);
        err.crc  = !err.data && crc != cmd[3:0];
        err.op   = !err.data && !err.crc && !op_legal(cmd[6:4]);
    end

    // rep marks the report cycle independently of the FSM so a new frame can start meanwhile
    always_ff @(posedge clk) begin
        if (rst) begin
            ftype     <= DATA;
            bit_cnt   <= 3'd0;
            cnt       <= 4'd0;
            shreg     <= 64'd0;
            cmd       <= 7'd0;
            rep       <= 1'b0;
            rep_bad   <= 1'b0;
            out_valid <= 1'b0;
            out_a     <= 32'd0;
            out_b     <= 32'd0;
            out_op    <= AND;
            out_err   <= 3'd0;
        end else begin
            rep       <= (state == DONE && ftype == CMD) || state == ERR;
            rep_bad   <= state == ERR;
            out_valid <= rep;
            if (state == START) begin
                ftype   <= sin;
                bit_cnt <= 3'd7;
            end
            if (state == BITS) begin
                bit_cnt <= bit_cnt - 3'd1;
                if (ftype == DATA)
                    shreg <= {shreg[62:0], sin};
                else
                    cmd <= {cmd[5:0], sin};
            end
            if (state == DONE && ftype == DATA)
                cnt <= cnt == 4'd9 ? 4'd9 : cnt + 4'd1;
            if (rep) begin
                out_err <= err;
                if (err == '0) begin
                    out_a  <= shreg[31:0];
                    out_b  <= shreg[63:32];
                    out_op <= cmd[6:4];
                end
                cnt   <= 4'd0;
                shreg <= 64'd0;
            end
        end
    end

endmodule

// File: doc/alu_serial_rx.md
# alu_serial_rx

Serial-side packet receiver for the ALU datapath. Deserializes the single-wire `sin` stream driven by the ALU BFM into the 32-bit operands A and B and a 3-bit opcode. Checks packet length, CRC4 and opcode legality, then presents one registered result (operands, opcode, error flags) per packet with a single-cycle `out_valid` strobe. It is the receiving end of the frame format the tester's `send_serial` and `send_serial_7frames` tasks generate.

## Interface
- `DATA_FRAMES`, 8: data frames per legal packet (B[31:24] first … A[7:0] last).
- `clk`  in  1  rising-edge clock; `sin` is sampled once per cycle, one bit per cycle.
- `rst`  in  1  synchronous, active-high reset.
- `sin`  in  1  serial input, idle high.
- `out_valid`  out  1  one-cycle strobe: `out_a`, `out_b`, `out_op` and `out_err` are valid.
- `out_a`  out  32  operand A.
- `out_b`  out  32  operand B.
- `out_op`  out  3  opcode (`alu_op_t`).
- `out_err`  out  3  {err_data, err_crc, err_op}; at most one bit set.
- `busy`  out  1  high from a detected start bit until the packet ends.

## Operation
- Frame format, 11 bits, MSB first: start `0`, type (`0` = data, `1` = cmd), d7..d0, stop `1`.
- Data frame: the byte is shifted into a 64-bit {B, A} register. A data-frame counter (4 bits) saturates at 9.
- Cmd frame payload: {`0`, op[2:0], crc[3:0]}. The cmd frame ends the packet.
- FSM states:
  - IDLE: `sin==0` → START.
  - START: sample the type bit → BITS.
  - BITS: 8 cycles, bit counter 7..0 → STOP.
  - STOP: `sin==1` → DONE; `sin==0` → ERR.
  - DONE: data frame → IDLE; cmd frame → REPORT.
  - ERR → REPORT with err_data.
  - REPORT → IDLE.
- CRC: polynomial x^4+x+1, initial value 0. It runs serially over every data bit and then over `1'b1` and op[2:0] from the cmd frame, i.e. over {B, A, 1'b1, op} (68 bits, MSB first). This matches `get_CRC4_d68`.
- Checks at REPORT, in priority order:
  - data-frame count != `DATA_FRAMES`, or a bad stop bit → err_data.
  - CRC mismatch → err_crc.
  - op not in {AND, OR, ADD, SUB} → err_op.
- On a successful packet, `out_a`, `out_b` and `out_op` are updated and `out_err` = 0.
- On any error, `out_err` is set. `out_a`, `out_b` and `out_op` keep their previous values.
- After REPORT, the data counter, shift register and CRC are cleared.
- A packet of fewer than 8 data frames (the BAD_DATA case) reports err_data only. A CRC mismatch is not also flagged.
- A 9th or later data frame is absorbed. Error is reported at the cmd frame.
- A bad stop bit reports immediately. The remaining frames of that packet then parse as a new packet.

## Timing
- Reset values: `out_valid`=0, `out_a`=0, `out_b`=0, `out_op`=AND (3'b000), `out_err`=0, `busy`=0, FSM=IDLE, all counters and CRC=0.
- Latency:
  - `out_valid` rises 2 cycles after the clock edge that samples the cmd-frame stop bit (STOP→DONE→REPORT, registered).
  - For err_data on a bad stop bit, `out_valid` rises 2 cycles after that edge (STOP→ERR→REPORT).
- `out_valid` is exactly 1 cycle wide. There is no backpressure: the consumer must accept it.
- Back-to-back frames are allowed: a start bit sampled in the cycle after stop is accepted from IDLE. DONE/REPORT must therefore overlap with IDLE start detection; one frame gap is not required.
- `rst` in any state: return to IDLE next cycle and drop the partial packet. No `out_valid` is generated for a packet cut off by reset.
- Between frames `busy` stays high until REPORT. After `busy` first rises, no timeout applies.

## Structure
- `alu_pkg` holds:
  - `alu_op_t` encodings: AND=3'b000, OR=3'b001, ADD=3'b100, SUB=3'b101, UNKNOWN=3'b010.
  - frame-type constants DATA=1'b0, CMD=1'b1.
  - the `err_flags_t` packed struct {data, crc, op}.
  - the existing `get_CRC4_d68`, which the scoreboard uses.
- One sub-module, `alu_crc4_ser`: ports `clk`, `rst`, `clr`, `en`, `din`, `crc[3:0]`. It is a 4-bit LFSR for x^4+x+1.

## Test plan
- A=32'h0000_0001, B=32'h0000_0002, op=ADD, correct CRC → one `out_valid`; `out_a`=1, `out_b`=2, `out_op`=3'b100, `out_err`=0.
- Same packet sent with crc+1 → `out_valid` with `out_err`=3'b010; `out_a` and `out_b` unchanged from the previous packet.
- 7 data frames then cmd (A=B=32'hFFFF_FFFF, SUB) → `out_err`=3'b100. The next legal packet (A=B=0, AND) → `out_err`=0, `out_a`=0.
- op=3'b010 with CRC computed over that op → `out_err`=3'b001.
- Assert `rst` during the 5th data frame, then send a legal OR packet with A=32'hDEAD_BEEF, B=32'h1234_5678 → exactly one `out_valid` with those values and no error.
- Stop bit forced to 0 in data frame 3 → `out_err`=3'b100 two cycles after that stop-bit sample; `busy` drops.
